// File: rtl/serving_ram_wb_bridge.sv
// Wishbone 32-bit slave to byte-wide SRAM bridge, four little-endian byte beats.
// Define SERVING_RAM_BRIDGE_SKIP_EN to visit only selected bytes on writes.
module serving_ram_wb_bridge #(
  parameter int depth = 256,
  parameter int aw = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_wen,
  output logic [aw-1:0] o_raddr,
  output logic          o_ren,
  input  logic [7:0]    i_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [aw-3:0] adr_q;
  logic [31:0]   dat_q;
  logic [2:0]    cnt;
  logic [1:0]    k;
  logic [1:0]    rb;
  logic          w_last;
  logic          start_ack;
  logic          unused;

  assign unused = ^i_wb_adr[1:0];

`ifdef SERVING_RAM_BRIDGE_SKIP_EN
  logic [3:0] rem;
  logic [3:0] rem_nx;

  // k is the lowest byte still pending
  always_comb begin
    k = 2'd0;
    if (rem[0])      k = 2'd0;
    else if (rem[1]) k = 2'd1;
    else if (rem[2]) k = 2'd2;
    else if (rem[3]) k = 2'd3;
  end

  assign rem_nx    = rem & ~(4'b0001 << k);
  assign w_last    = (rem_nx == 4'b0000);
  assign start_ack = (i_wb_sel == 4'b0000);
  assign o_wen     = (state == WRITE);
`else
  logic [3:0] sel_q;

  assign k         = cnt[1:0];
  assign w_last    = (cnt[1:0] == 2'd3);
  assign start_ack = 1'b0;
  assign o_wen     = (state == WRITE) & sel_q[k];
`endif

  assign rb      = cnt[1:0] - 2'd1;
  assign o_waddr = {adr_q, k};
  assign o_wdata = dat_q[{k, 3'b000} +: 8];
  assign o_raddr = {adr_q, cnt[1:0]};
  assign o_ren   = (state == READ) & ~cnt[2];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_wb_cyc) begin
          if (!i_wb_we)       state_nx = READ;
          else if (start_ack) state_nx = ACK;
          else                state_nx = WRITE;
        end
      end
      WRITE: if (w_last) state_nx = i_wb_cyc ? ACK : IDLE;
      // capture of byte 3 happens on the cnt==4 edge
      READ:  if (cnt[2]) state_nx = i_wb_cyc ? ACK : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'h0;
      cnt      <= 3'd0;
      adr_q    <= '0;
      dat_q    <= 32'h0;
`ifdef SERVING_RAM_BRIDGE_SKIP_EN
      rem      <= 4'h0;
`else
      sel_q    <= 4'h0;
`endif
    end else begin
      state    <= state_nx;
      o_wb_ack <= (state_nx == ACK);
      if (state == IDLE && i_wb_cyc) begin
        adr_q <= i_wb_adr[aw-1:2];
        dat_q <= i_wb_dat;
        cnt   <= 3'd0;
`ifdef SERVING_RAM_BRIDGE_SKIP_EN
        rem   <= i_wb_sel;
`else
        sel_q <= i_wb_sel;
`endif
      end
      if (state == WRITE) begin
        cnt <= cnt + 3'd1;
`ifdef SERVING_RAM_BRIDGE_SKIP_EN
        rem <= rem_nx;
`endif
      end
      if (state == READ) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) o_wb_rdt[{rb, 3'b000} +: 8] <= i_rdata;
      end
    end
  end

endmodule

// File: tb/tb_serving_ram_wb_bridge.sv
// Bench for serving_ram_wb_bridge: directed table, reset corners, random traffic.
// Expected beats and acks come from a transaction-level model of the bridge.
module tb_serving_ram_wb_bridge;

  localparam int DEPTH = 256;
  localparam int AW = 8;
`ifdef SERVING_RAM_BRIDGE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] wb_adr = '0;
  logic [31:0]   wb_dat = '0;
  logic [3:0]    wb_sel = '0;
  logic          wb_we = 1'b0;
  logic          wb_cyc = 1'b0;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          wen;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [7:0]    rdata = 8'h0;

  serving_ram_wb_bridge #(.depth(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
    .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          drop;
    int          exp_ack;
    logic [31:0] exp_rdt;
    bit          chk_rdt;
  } vec_t;

  typedef struct {
    int         off;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  function automatic vec_t mk(logic [7:0] a, logic [31:0] d, logic [3:0] s,
                              logic w, int dr, int ea, logic [31:0] er,
                              bit cr);
    vec_t v;
    v.adr = a; v.dat = d; v.sel = s; v.we = w; v.drop = dr;
    v.exp_ack = ea; v.exp_rdt = er; v.chk_rdt = cr;
    return v;
  endfunction

  function automatic logic [63:0] pk(ev_t e);
    return {32'(e.off), 16'h0, e.a, e.d};
  endfunction

  // Starts at a negedge in an idle cycle; returns at a negedge in an idle cycle.
  task automatic run_txn(input vec_t v, input bit use_tab);
    ev_t exp_w[$];
    ev_t got_w[$];
    ev_t exp_r[$];
    ev_t got_r[$];
    ev_t e;
    int pop, eack, gack, nack;
    logic [7:0] base, ba;
    logic [31:0] exp_word, rdt;
    bit overlap;
    base = {v.adr[7:2], 2'b00};
    pop = 0;
    for (int i = 0; i < 4; i++) begin
      ba = base + 8'(i);
      exp_word[8*i +: 8] = ref_mem[ba];
      if (v.we && v.sel[i]) begin
        e.off = SKIP ? 1 + pop : 1 + i;
        e.a = ba;
        e.d = v.dat[8*i +: 8];
        exp_w.push_back(e);
        pop++;
      end
      if (!v.we) begin
        e.off = 1 + i; e.a = ba; e.d = 8'h0;
        exp_r.push_back(e);
      end
    end
    eack = v.we ? (SKIP ? 1 + pop : 5) : 6;
    if (v.drop > 0 && v.drop <= eack - 1) eack = -1;
    wb_adr = v.adr; wb_dat = v.dat; wb_sel = v.sel; wb_we = v.we;
    wb_cyc = 1'b1;
    gack = -1; nack = 0; overlap = 1'b0; rdt = '0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (wen) begin
        e.off = n; e.a = waddr; e.d = wdata; got_w.push_back(e);
      end
      if (ren) begin
        e.off = n; e.a = raddr; e.d = 8'h0; got_r.push_back(e);
      end
      if (wen && ren) overlap = 1'b1;
      if (wb_ack) begin
        nack++;
        if (gack < 0) begin gack = n; rdt = wb_rdt; end
      end
      if (n == v.drop) wb_cyc = 1'b0;
      if (gack > 0 && n == gack) wb_cyc = 1'b0;
      if (gack > 0 && n == gack + 1) break;
    end
    wb_cyc = 1'b0;
    check("ack_cycle", 64'(gack), 64'(eack));
    check("ack_count", 64'(nack), (eack < 0) ? 64'd0 : 64'd1);
    check("wen_count", 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check("wen_beat", pk(got_w[i]), pk(exp_w[i]));
    check("ren_count", 64'(got_r.size()), 64'(exp_r.size()));
    for (int i = 0; i < got_r.size() && i < exp_r.size(); i++)
      check("ren_beat", pk(got_r[i]), pk(exp_r[i]));
    check("wen_ren_overlap", 64'(overlap), 64'd0);
    if (!v.we && eack > 0) check("read_word", 64'(rdt), 64'(exp_word));
    if (use_tab) begin
      check("tab_ack", 64'(gack), 64'(v.exp_ack));
      if (v.chk_rdt) check("tab_rdt", 64'(rdt), 64'(v.exp_rdt));
    end
    foreach (exp_w[i]) ref_mem[exp_w[i].a] = exp_w[i].d;
  endtask

  vec_t tab[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic seen;
    tab[0]  = mk(8'h40, 32'h0BADF00D, 4'hF, 1'b1, 0, 5, 32'h0, 1'b0);
    tab[1]  = mk(8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 0, 5, 32'h0, 1'b0);
    tab[2]  = mk(8'h10, 32'h11223344, 4'h5, 1'b1, 0, SKIP ? 3 : 5, 32'h0, 1'b0);
    tab[3]  = mk(8'h10, 32'h0, 4'h0, 1'b0, 0, 6, 32'hDE22BE44, 1'b1);
    tab[4]  = mk(8'h40, 32'h0, 4'hF, 1'b0, 0, 6, 32'h0BADF00D, 1'b1);
    tab[5]  = mk(8'h10, 32'hCAFEF00D, 4'hF, 1'b1, 2, -1, 32'h0, 1'b0);
    tab[6]  = mk(8'h10, 32'h0, 4'h3, 1'b0, 0, 6, 32'hCAFEF00D, 1'b1);
    tab[7]  = mk(8'h20, 32'hA5000000, 4'h8, 1'b1, 0, SKIP ? 2 : 5, 32'h0, 1'b0);
    tab[8]  = mk(8'h24, 32'hFFFFFFFF, 4'h0, 1'b1, 0, SKIP ? 1 : 5, 32'h0, 1'b0);
    tab[9]  = mk(8'h23, 32'h0, 4'h0, 1'b0, 0, 6, 32'h0, 1'b0);
    tab[10] = mk(8'hFF, 32'h12345678, 4'hF, 1'b1, 0, 5, 32'h0, 1'b0);
    tab[11] = mk(8'hFC, 32'h0, 4'h0, 1'b0, 0, 6, 32'h12345678, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // held in reset with a live request
    wb_adr = 8'h40; wb_dat = 32'h0BADF00D; wb_sel = 4'hF;
    wb_we = 1'b1; wb_cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {5'h0, wb_ack, wen, ren, waddr, wdata, raddr, wb_rdt}, 64'h0);
    end
    rst_n = 1'b1;

    foreach (tab[i]) run_txn(tab[i], 1'b1);

    // reset pulsed during a read
    wb_adr = 8'h10; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {5'h0, wb_ack, wen, ren, waddr, wdata, raddr, wb_rdt}, 64'h0);
    wb_cyc = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (wb_ack || wen || ren) seen = 1'b1;
    end
    check("midreset_quiet", 64'(seen), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      v.adr = 8'($urandom);
      v.dat = $urandom;
      v.sel = 4'($urandom_range(0, 15));
      v.we = 1'($urandom_range(0, 1));
      v.drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      v.exp_ack = 0; v.exp_rdt = '0; v.chk_rdt = 1'b0;
      run_txn(v, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
